// File: rtl/rr_logb_flow_ctrl.sv
// Credit-based flow controller for the logging-bus merge tree: issues tree ready
// against downstream FIFO credits, runs the flush sequence, and keeps beat/bit stats.
module rr_logb_flow_ctrl #(
  parameter int unsigned FULL_WIDTH   = 1024,
  parameter int unsigned OFFSET_WIDTH = $clog2(FULL_WIDTH + 1),
  parameter int unsigned CREDITS      = 16,
  parameter int unsigned PIPE_LAT     = 3,
  parameter int unsigned CREDIT_W     = $clog2(CREDITS + 1)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cfg_enable,
  input  logic                    flush_req,
  output logic                    flush_done,
  input  logic                    tree_any_valid,
  input  logic [OFFSET_WIDTH-1:0] tree_len,
  output logic                    tree_ready,
  output logic                    fifo_push,
  input  logic                    credit_return,
  output logic [CREDIT_W-1:0]     credit_cnt,
  output logic [31:0]             beat_cnt,
  output logic [47:0]             bit_cnt,
  output logic                    overflow_err
);

  localparam int unsigned         DRAIN_W      = $clog2(PIPE_LAT + 2);
  localparam logic [DRAIN_W-1:0]  DRAIN_END    = DRAIN_W'(PIPE_LAT + 1);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX   = CREDIT_W'(CREDITS);
  localparam logic [CREDIT_W-1:0] CREDIT_SLACK = CREDIT_W'(PIPE_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [31:0]         beat_q, beat_d;
  logic [47:0]         bit_q, bit_d;
  logic                ovf_q, ovf_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                accept;

  // The tree may still deliver beats after ready falls, so every valid beat is taken.
  assign accept    = tree_any_valid;
  assign fifo_push = tree_any_valid;

  always_comb begin
    state_d  = state_q;
    drain_d  = '0;
    credit_d = credit_q;
    beat_d   = beat_q;
    bit_d    = bit_q;
    ovf_d    = ovf_q;

    if (accept) begin
      beat_d = beat_q + 32'd1;
      bit_d  = bit_q + 48'(tree_len);
      if (credit_q == '0) ovf_d = 1'b1;
    end

    // Saturating credit update: no wrap below zero, extra returns ignored at full.
    unique case ({credit_return, accept})
      2'b10:   if (credit_q != CREDIT_MAX) credit_d = credit_q + CREDIT_W'(1);
      2'b01:   if (credit_q != '0)         credit_d = credit_q - CREDIT_W'(1);
      default: credit_d = credit_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (flush_req)       state_d = DONE;
        else if (cfg_enable) state_d = RUN;
      end
      RUN: begin
        if (flush_req || !cfg_enable) state_d = DRAIN;
      end
      DRAIN: begin
        drain_d = accept ? '0 : drain_q + DRAIN_W'(1);
        if (drain_d == DRAIN_END) state_d = DONE;
      end
      DONE: begin
        if (!flush_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Ready only while staying in RUN with more than the in-flight slack left.
    ready_d = (state_q == RUN) && (state_d == RUN) && (credit_d > CREDIT_SLACK);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      drain_q  <= '0;
      credit_q <= CREDIT_MAX;
      beat_q   <= '0;
      bit_q    <= '0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      credit_q <= credit_d;
      beat_q   <= beat_d;
      bit_q    <= bit_d;
      ovf_q    <= ovf_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign tree_ready   = ready_q;
  assign flush_done   = done_q;
  assign credit_cnt   = credit_q;
  assign beat_cnt     = beat_q;
  assign bit_cnt      = bit_q;
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_rr_logb_flow_ctrl.sv
// Bench for rr_logb_flow_ctrl: directed vector table, hand-written flush/reset
// sequences, then random traffic against a cycle-level reference model.
module tb_rr_logb_flow_ctrl;

  localparam int unsigned OW       = 11;
  localparam int unsigned CW       = 5;
  localparam int          CREDITS  = 16;
  localparam int          PIPE_LAT = 3;
  localparam int          S_IDLE = 0, S_RUN = 1, S_DRAIN = 2, S_DONE = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic          cfg_enable, flush_req, flush_done;
  logic          tree_any_valid, tree_ready, fifo_push, credit_return, overflow_err;
  logic [OW-1:0] tree_len;
  logic [CW-1:0] credit_cnt;
  logic [31:0]   beat_cnt;
  logic [47:0]   bit_cnt;

  int n_cmp = 0;
  int n_err = 0;

  rr_logb_flow_ctrl dut (
    .clk(clk), .rstn(rstn), .cfg_enable(cfg_enable), .flush_req(flush_req),
    .flush_done(flush_done), .tree_any_valid(tree_any_valid), .tree_len(tree_len),
    .tree_ready(tree_ready), .fifo_push(fifo_push), .credit_return(credit_return),
    .credit_cnt(credit_cnt), .beat_cnt(beat_cnt), .bit_cnt(bit_cnt),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en, fr, v;
    logic [OW-1:0] len;
    logic          ret;
    logic          exp_ready;
    int            exp_credit;
    int            exp_beats;
    int            exp_bits;
    logic          exp_ovf;
  } vec_t;

  vec_t tbl[20];

  // Reference model: abstract flow-control state after each clock.
  bit          use_model = 1'b0;
  int          m_st, m_credit, m_idle;
  logic [31:0] m_beats;
  logic [47:0] m_bits;
  logic        m_ovf, m_ready, m_done;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = S_IDLE; m_credit = CREDITS; m_idle = 0;
    m_beats = '0; m_bits = '0; m_ovf = 1'b0; m_ready = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic fr, input logic v,
                            input logic [OW-1:0] len, input logic ret);
    int ns;
    int was;
    was = m_st;
    ns  = m_st;
    if (v) begin
      if (m_credit == 0) m_ovf = 1'b1;
      m_beats = m_beats + 32'd1;
      m_bits  = m_bits + 48'(len);
    end
    m_credit = m_credit + int'(ret) - int'(v);
    if (m_credit < 0)       m_credit = 0;
    if (m_credit > CREDITS) m_credit = CREDITS;
    case (m_st)
      S_IDLE:  if (fr) ns = S_DONE; else if (en) ns = S_RUN;
      S_RUN:   if (fr || !en) ns = S_DRAIN;
      S_DRAIN: begin
        m_idle = v ? 0 : m_idle + 1;
        if (m_idle == PIPE_LAT + 1) ns = S_DONE;
      end
      default: if (!fr) ns = S_IDLE;
    endcase
    if (ns != S_DRAIN) m_idle = 0;
    m_ready = (was == S_RUN) && (ns == S_RUN) && (m_credit > PIPE_LAT);
    m_done  = (ns == S_DONE);
    m_st    = ns;
  endtask

  // Drive one cycle of inputs, advance one clock, and sample just after the edge.
  task automatic step(input logic en, input logic fr, input logic v,
                      input logic [OW-1:0] len, input logic ret);
    cfg_enable = en; flush_req = fr; tree_any_valid = v; tree_len = len; credit_return = ret;
    #1;
    chk("fifo_push", fifo_push, v);
    @(posedge clk);
    #1;
    if (use_model) begin
      model_step(en, fr, v, len, ret);
      chk("m_ready",  tree_ready,   m_ready);
      chk("m_credit", credit_cnt,   m_credit);
      chk("m_beats",  beat_cnt,     m_beats);
      chk("m_bits",   bit_cnt,      m_bits);
      chk("m_ovf",    overflow_err, m_ovf);
      chk("m_done",   flush_done,   m_done);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"},  tree_ready,   0);
    chk({tag, "_credit"}, credit_cnt,   CREDITS);
    chk({tag, "_beats"},  beat_cnt,     0);
    chk({tag, "_bits"},   bit_cnt,      0);
    chk({tag, "_ovf"},    overflow_err, 0);
    chk({tag, "_done"},   flush_done,   0);
  endtask

  initial begin
    logic en_r, fr_r;

    tbl[0] = '{1'b1, 1'b0, 1'b0, 11'd0, 1'b0, 1'b0, 16, 0, 0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 11'd0, 1'b0, 1'b1, 16, 0, 0, 1'b0};
    for (int i = 0; i < 13; i++)
      tbl[2+i] = '{1'b1, 1'b0, 1'b1, 11'd100, 1'b0, ((15 - i) > PIPE_LAT),
                   15 - i, i + 1, 100 * (i + 1), 1'b0};
    for (int i = 0; i < 3; i++)
      tbl[15+i] = '{1'b1, 1'b0, 1'b1, 11'd100, 1'b0, 1'b0, 2 - i, 14 + i, 1400 + 100 * i, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 1'b1, 11'd100, 1'b0, 1'b0, 0, 17, 1700, 1'b1};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 11'd0,   1'b0, 1'b0, 0, 17, 1700, 1'b1};

    rstn = 1'b0;
    cfg_enable = 1'b0; flush_req = 1'b0; tree_any_valid = 1'b0;
    tree_len = '0; credit_return = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    #2 rstn = 1'b1;

    // Enable, stream to zero credits, then one overflowing beat.
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].en, tbl[i].fr, tbl[i].v, tbl[i].len, tbl[i].ret);
      chk($sformatf("tbl%0d_ready", i),  tree_ready,   tbl[i].exp_ready);
      chk($sformatf("tbl%0d_credit", i), credit_cnt,   tbl[i].exp_credit);
      chk($sformatf("tbl%0d_beats", i),  beat_cnt,     tbl[i].exp_beats);
      chk($sformatf("tbl%0d_bits", i),   bit_cnt,      tbl[i].exp_bits);
      chk($sformatf("tbl%0d_ovf", i),    overflow_err, tbl[i].exp_ovf);
    end

    // Refill to 8, then 20 cycles of simultaneous return and accept.
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, 1'b0, 1'b0, 11'd0, 1'b1);
      chk("refill_credit", credit_cnt, k);
      chk("refill_ready",  tree_ready, (k > PIPE_LAT));
    end
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, 1'b1, 11'd7, 1'b1);
      chk("both_credit", credit_cnt, 8);
    end
    chk("both_beats", beat_cnt, 37);
    chk("both_bits",  bit_cnt,  1840);
    chk("both_ready", tree_ready, 1);
    chk("both_ovf",   overflow_err, 1);

    // Flush with beats 1 and 3 cycles later; done after 4 idle cycles.
    step(1'b1, 1'b1, 1'b0, 11'd0, 1'b0);
    chk("fl_ready", tree_ready, 0);
    chk("fl_done0", flush_done, 0);
    step(1'b1, 1'b1, 1'b1, 11'd5, 1'b0);
    step(1'b1, 1'b1, 1'b0, 11'd0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 11'd5, 1'b0);
    chk("fl_credit", credit_cnt, 6);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b1, 1'b0, 11'd0, 1'b0);
      chk($sformatf("fl_idle%0d_done", k + 1), flush_done, (k == 3));
    end
    step(1'b1, 1'b1, 1'b0, 11'd0, 1'b0);
    chk("fl_done_hold", flush_done, 1);
    chk("fl_hold_ready", tree_ready, 0);
    step(1'b1, 1'b0, 1'b0, 11'd0, 1'b0);
    chk("fl_done_fall", flush_done, 0);
    chk("fl_beats", beat_cnt, 39);
    chk("fl_bits",  bit_cnt,  1850);

    // Back to RUN, start a flush, reset in the middle of DRAIN.
    step(1'b1, 1'b0, 1'b0, 11'd0, 1'b0);
    chk("rerun_ready0", tree_ready, 0);
    step(1'b1, 1'b0, 1'b0, 11'd0, 1'b0);
    chk("rerun_ready1", tree_ready, 1);
    step(1'b1, 1'b1, 1'b0, 11'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 11'd0, 1'b0);
    cfg_enable = 1'b0; flush_req = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk_reset_vals("midrst");
    #2 rstn = 1'b1;
    step(1'b0, 1'b0, 1'b1, 11'd9, 1'b0);
    step(1'b0, 1'b0, 1'b1, 11'd9, 1'b0);
    chk("post_rst_credit", credit_cnt, 14);
    chk("post_rst_beats",  beat_cnt,   2);
    chk("post_rst_bits",   bit_cnt,    18);
    chk("post_rst_ovf",    overflow_err, 0);
    chk("post_rst_ready",  tree_ready, 0);
    chk("post_rst_done",   flush_done, 0);

    // Random traffic against the reference model.
    cfg_enable = 1'b0; flush_req = 1'b0; tree_any_valid = 1'b0; credit_return = 1'b0;
    #2 rstn = 1'b0;
    #2 rstn = 1'b1;
    model_reset();
    use_model = 1'b1;
    en_r = 1'b1;
    fr_r = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(23, 0) == 0) en_r = ~en_r;
      if ($urandom_range(15, 0) == 0) fr_r = ~fr_r;
      step(en_r, fr_r, ($urandom_range(9, 0) < 4), OW'($urandom_range(1024, 0)),
           ($urandom_range(9, 0) < 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_logb_flow_ctrl.md
Name: rr_logb_flow_ctrl

Overview:
- Flow controller between the top of the packed logging-bus merge tree and the downstream trace FIFO / PCIe writer.
- Owns the tree's ready input and issues it against downstream credits.
- Reserves slack so beats already in flight in the pipelined ready path always land safely.
- Provides a flush sequence that stalls the tree, waits for in-flight beats to drain, then reports completion; also keeps beat and bit statistics for the trace decoder.

Parameters:
- FULL_WIDTH, 1024, width of the packed logb data bus.
- OFFSET_WIDTH, $clog2(FULL_WIDTH+1), width of the len field.
- CREDITS, 16, downstream FIFO depth in beats (initial credit count).
- PIPE_LAT, 3, cycles between a change of tree_ready and the tree honouring it (merge-tree depth plus ready pipe).
- CREDIT_W, $clog2(CREDITS+1), credit counter width.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- cfg_enable  in  1  level; 1 allows recording.
- flush_req  in  1  level; request to drain and stop.
- flush_done  out  1  high in DONE state.
- tree_any_valid  in  1  a beat is presented by the merge tree this cycle.
- tree_len  in  OFFSET_WIDTH  valid bits in the beat; meaningful only when tree_any_valid=1.
- tree_ready  out  1  registered ready to the merge tree.
- fifo_push  out  1  combinational; equals tree_any_valid (beat forwarded to the FIFO this cycle).
- credit_return  in  1  one pulse per beat popped from the downstream FIFO.
- credit_cnt  out  CREDIT_W  current credits.
- beat_cnt  out  32  beats accepted since reset.
- bit_cnt  out  48  sum of tree_len over accepted beats.
- overflow_err  out  1  sticky; a beat arrived while credit_cnt==0.

Behaviour:
- Reset (async, rstn=0): state=IDLE, tree_ready=0, credit_cnt=CREDITS, beat_cnt=0, bit_cnt=0, overflow_err=0, flush_done=0, drain counter=0.
- Accept rule:
  - Every cycle with tree_any_valid=1 is an accepted beat, regardless of tree_ready, since the tree may deliver up to PIPE_LAT beats after ready falls.
  - fifo_push=tree_any_valid.
- Credit update each cycle: credit_cnt += credit_return - accept.
  - Simultaneous return and accept leaves it unchanged.
  - Accept at credit_cnt==0 sets overflow_err and holds credit_cnt at 0 (no wrap).
  - A return at credit_cnt==CREDITS is ignored (saturate).
- Ready generation (registered): tree_ready_next = (state==RUN) && (credit_cnt_next > PIPE_LAT).
  - Guarantees no overflow with a compliant tree.
- Counters:
  - beat_cnt +1 per accept; wraps at 2^32.
  - bit_cnt += zero-extended tree_len per accept; wraps at 2^48.
  - Both count in all states.
- FSM:
  - IDLE: tree_ready=0. Go to RUN when cfg_enable=1 && flush_req=0.
  - RUN: go to DRAIN when flush_req=1 or cfg_enable=0. tree_ready drops the cycle after the transition is taken.
  - DRAIN: tree_ready=0.
    - drain counter clears on any accept; otherwise it increments.
    - Go to DONE when the counter reaches PIPE_LAT+1 (PIPE_LAT+1 consecutive idle cycles).
  - DONE: flush_done=1, tree_ready=0. Return to IDLE when flush_req=0; flush_done deasserts that same transition cycle.
  - flush_req=1 in IDLE: go directly to DONE (nothing in flight).
- Latency: tree_ready responds 1 cycle after a credit or state change. Counters and credit_cnt are registered (visible the next cycle).
- cfg_enable toggling during DRAIN/DONE has no effect until IDLE.
- An enable-drop-triggered DONE with flush_req=0 returns to IDLE on the next cycle.
- Reset mid-DRAIN aborts the flush. In-flight beats after reset are counted against fresh credits.

Test Plan:
- Reset, then cfg_enable=1 with no traffic:
  - tree_ready=1 from the 2nd cycle after enable (IDLE→RUN, then registered ready).
  - credit_cnt=16.
- Stream 13 consecutive beats (len=100 each) with no credit_return:
  - tree_ready falls once credit_cnt_next≤3, i.e. in the cycle after the 13th accept (credit_cnt=3).
  - Then 3 trailing beats arrive → credit_cnt=0, overflow_err=0, beat_cnt=16, bit_cnt=1600.
- One extra beat at credit_cnt=0:
  - overflow_err=1 and sticky; credit_cnt stays 0.
- Simultaneous credit_return and accept for 20 cycles at credit_cnt=8: credit_cnt stays 8, beat_cnt +20.
- flush_req=1 in RUN with 2 beats arriving 1 and 3 cycles later:
  - Drain counter restarts after each beat.
  - flush_done rises exactly 4 idle cycles after the last beat, then falls when flush_req drops.
- Assert rstn=0 mid-DRAIN:
  - All outputs return to reset values immediately (async).
  - credit_cnt=16, FSM in IDLE.
